// File: rtl/serial_pattern_gen_if.sv
// Serial pattern generator bus.
//   master : bench/controller side. Drives EN, MODE, LOAD, LOAD_DATA and
//            observes the serial output.
//   slave  : generator side. Consumes the controls and drives Dout, Dvalid,
//            SOF and BIT_IDX.
interface serial_pattern_gen_if #(
  parameter int unsigned WORD_W = 8
);
  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic              EN;         // run enable; low freezes the generator
  logic [1:0]        MODE;       // 0 pattern, 1 PRBS7, 2 alternating, 3 idle-mark
  logic              LOAD;       // one-cycle strobe: capture LOAD_DATA
  logic [WORD_W-1:0] LOAD_DATA;  // new pattern word
  logic              Dout;       // serial data bit, held for one bit period
  logic              Dvalid;     // pulse on the cycle Dout takes a new bit
  logic              SOF;        // with Dvalid when the bit is index 0 of a word
  logic [IDX_W-1:0]  BIT_IDX;    // index of the bit currently on Dout

  modport master (
    output EN, MODE, LOAD, LOAD_DATA,
    input  Dout, Dvalid, SOF, BIT_IDX
  );

  modport slave (
    input  EN, MODE, LOAD, LOAD_DATA,
    output Dout, Dvalid, SOF, BIT_IDX
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// Selectable serial bit-stream source for QPSK modulator bring-up.
// Sources: loadable fixed word (LSB first), PRBS7 (x^7+x^6+1), alternating
// 0/1, idle-mark (all ones). A programmable divider sets the bit period to
// DIV clock cycles; Dvalid/SOF/BIT_IDX let the I/Q mapper align to symbols
// and words.
// Ports:
//   CLK : system clock, rising edge
//   RST : synchronous reset, active-high
//   bus : serial_pattern_gen_if slave modport
//         (EN, MODE, LOAD, LOAD_DATA in; Dout, Dvalid, SOF, BIT_IDX out)
module serial_pattern_gen #(
  parameter int unsigned       WORD_W  = 8,
  parameter logic [WORD_W-1:0] PATTERN = WORD_W'(8'b01111000),
  parameter int unsigned       DIV     = 1,
  parameter int unsigned       DIV_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  serial_pattern_gen_if.slave   bus
);

  localparam int unsigned      IDX_W    = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [6:0]       LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    SRC_PATTERN = 2'd0,
    SRC_PRBS    = 2'd1,
    SRC_ALT     = 2'd2,
    SRC_MARK    = 2'd3
  } src_e;

  logic [DIV_W-1:0]  div_q,    div_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] word_q,   word_d;
  logic [6:0]        lfsr_q,   lfsr_d;
  src_e              mode_q,   mode_d;
  logic              tog_q,    tog_d;
  logic              dout_q,   dout_d;
  logic              dvalid_q, dvalid_d;
  logic              sof_q,    sof_d;
  logic [IDX_W-1:0]  bidx_q,   bidx_d;
  logic              tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= PATTERN;
      word_q   <= PATTERN;
      lfsr_q   <= LFSR_SEED;
      mode_q   <= SRC_PATTERN;
      tog_q    <= 1'b0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      sof_q    <= 1'b0;
      bidx_q   <= '0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      lfsr_q   <= lfsr_d;
      mode_q   <= mode_d;
      tog_q    <= tog_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      sof_q    <= sof_d;
      bidx_q   <= bidx_d;
    end
  end

  always_comb begin
    div_d    = div_q;
    idx_d    = idx_q;
    // shadow_d doubles as the LOAD bypass: a LOAD on a boundary tick feeds
    // LOAD_DATA straight into the word that starts on that tick.
    shadow_d = bus.LOAD ? bus.LOAD_DATA : shadow_q;
    word_d   = word_q;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    tog_d    = tog_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    sof_d    = 1'b0;
    bidx_d   = bidx_q;

    tick = bus.EN && (div_q == DIV_LAST);

    if (bus.EN) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      // Mode and word only change at a word boundary; the boundary bit
      // itself already uses the newly latched values.
      if (idx_q == '0) begin
        mode_d = src_e'(bus.MODE);
        word_d = shadow_d;
      end

      unique case (mode_d)
        SRC_PATTERN: dout_d = word_d[idx_q];
        SRC_PRBS: begin
          dout_d = lfsr_q[6];
          lfsr_d = (lfsr_q == '0) ? LFSR_SEED
                                  : {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
        SRC_ALT: begin
          dout_d = tog_q;
          tog_d  = ~tog_q;
        end
        SRC_MARK: dout_d = 1'b1;
      endcase

      dvalid_d = 1'b1;
      sof_d    = (idx_q == '0);
      bidx_d   = idx_q;
      idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  assign bus.Dout    = dout_q;
  assign bus.Dvalid  = dvalid_q;
  assign bus.SOF     = sof_q;
  assign bus.BIT_IDX = bidx_q;

endmodule
